order_stream_arbiter: RTL
=========================

Name:
order_stream_arbiter

Overview:
- Weighted round-robin arbiter merging N_PORTS independent order streams into one output stream toward the risk-check pipeline.
- Sits between the per-session ingress fifo_axis instances and the single shared downstream stream.
- Sequences which ingress FIFO drains, limits each grant to QUANTUM beats, tags each output beat with its source port, and registers the output stage.
- Output handshake is valid/ready, identical to the FIFO interface.

Parameters:
- N_PORTS, 4, number of input streams (2..8).
- WIDTH, 64, data width per beat.
- QUANTUM, 4, maximum consecutive beats accepted from one port per grant (1..255).
- IDW, derived localparam = clog2(N_PORTS), source-tag width (2 at default).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  N_PORTS  per-port beat valid; bit i is port i.
- s_ready  out  N_PORTS  per-port ready.
- s_data  in  N_PORTS*WIDTH  port i occupies bits [i*WIDTH +: WIDTH].
- port_en  in  N_PORTS  per-port enable; a disabled port is never granted.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  WIDTH  output beat.
- m_src  out  IDW  source port index of m_data.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=N_PORTS-1 (so port 0 wins first), beat_cnt=0, m_valid=0, m_data=0, m_src=0, s_ready=0, busy=0.
- Output register: load_ok = !m_valid || m_ready. A beat held with m_valid=1 and m_ready=0 keeps m_data/m_src stable until accepted.
- IDLE state:
  - s_ready all 0.
  - Evaluate req[i] = s_valid[i] & port_en[i], searching from rr_ptr+1 with wrap modulo N_PORTS.
  - On a hit k: register gnt=k, rr_ptr=k, beat_cnt=0, go to GRANT.
  - No hit: stay in IDLE.
- GRANT state:
  - s_ready[gnt] = load_ok & port_en[gnt]; all other s_ready bits are 0.
  - A transfer (s_valid[gnt] & s_ready[gnt]) loads m_data = s_data[gnt], m_src = gnt, m_valid = 1 on the next edge. Latency is 1 cycle from input handshake to m_valid.
  - If load_ok and there is no transfer, m_valid clears once the held beat is taken.
- GRANT exit to IDLE, evaluated each cycle; the first true condition applies and the beat in that cycle still transfers:
  - (a) a transfer with beat_cnt==QUANTUM-1;
  - (b) port_en[gnt]==0;
  - (c) load_ok==1 and s_valid[gnt]==0 (port ran dry).
  - Otherwise each transfer increments beat_cnt.
  - load_ok==0 never causes release; the grant is held through backpressure.
- Fairness: with all ports requesting continuously, each port gets QUANTUM beats in turn, and there is 1 idle bubble cycle per grant change. Sustained throughput is QUANTUM/(QUANTUM+1).
- Beats from one port are never reordered. No beat is dropped or duplicated.
- port_en change during IDLE takes effect in the same cycle's arbitration.
- Reset mid-operation: the output register and any in-flight beat are discarded. The upstream FIFO retains unaccepted beats because s_ready goes 0 immediately.

Test Plan:
- Port 2 only, sends 3 beats D0..D2 back-to-back, m_ready=1 -> IDLE 1 cycle, then m_data D0,D1,D2 on consecutive cycles with m_src=2. Grant releases on dry and returns to IDLE.
- All 4 ports continuously valid, QUANTUM=4, m_ready=1 -> m_src sequence 0×4, bubble, 1×4, bubble, 2×4, bubble, 3×4, bubble, 0... (20 output cycles for 16 beats).
- Port 1 granted, m_ready held 0 for 5 cycles after first beat -> m_valid=1 and m_data stable for all 5 cycles, s_ready[1]=0 throughout. Stream resumes with no loss; beat_cnt is unaffected by stall cycles.
- Port 0 granted, port_en[0] dropped after beat 2 -> at most 2 beats from port 0, s_ready[0]=0 from that cycle, next grant goes to port 1. Port 0 is not regranted while disabled.
- Ports 0 and 3 valid, rr_ptr=0 after port 0 grant ends -> next grant is port 3 (wrap search 1,2,3), then port 0.
- Assert rst_n low mid-burst on port 2 -> same cycle m_valid=0, s_ready=0, busy=0. After release, first grant goes to the lowest requesting enabled port.

Source files
------------

// File: rtl/order_stream_arbiter.sv
// Weighted round-robin merge of N_PORTS ingress streams into one registered output stream.
// Each grant drains at most QUANTUM beats from one port; every output beat carries its source index.
//
// state   | meaning
// S_IDLE  | no port owns the output; round-robin search for the next requester
// S_GRANT | port gnt_q owns the output until quantum, disable or dry-out
module order_stream_arbiter #(
  parameter  int N_PORTS = 4,
  parameter  int WIDTH   = 64,
  parameter  int QUANTUM = 4,
  localparam int IDW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_PORTS-1:0]       s_valid,
  output logic [N_PORTS-1:0]       s_ready,
  input  logic [N_PORTS*WIDTH-1:0] s_data,
  input  logic [N_PORTS-1:0]       port_en,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [IDW-1:0]           m_src,
  output logic                     busy
);

  localparam int         CIW       = IDW + 1;
  localparam logic [7:0] LAST_BEAT = 8'(QUANTUM - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [IDW-1:0]   m_src_q, m_src_d;

  logic [N_PORTS-1:0] req;
  logic               load_ok;
  logic               gnt_valid;
  logic               gnt_en;
  logic               gnt_rdy;
  logic               xfer;
  logic [WIDTH-1:0]   gnt_data;
  logic               hit;
  logic [IDW-1:0]     hit_idx;
  logic [CIW-1:0]     cand;

  assign req       = s_valid & port_en;
  assign load_ok   = !m_valid_q || m_ready;
  assign gnt_valid = s_valid[gnt_q];
  assign gnt_en    = port_en[gnt_q];
  assign gnt_rdy   = load_ok && gnt_en;
  assign xfer      = (state_q == S_GRANT) && gnt_valid && gnt_rdy;
  assign gnt_data  = s_data[gnt_q*WIDTH +: WIDTH];

  // Search starts just past the last winner so every port gets a turn.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    cand    = '0;
    for (int off = 1; off <= N_PORTS; off++) begin
      cand = {1'b0, rr_ptr_q} + CIW'(off);
      if (cand >= CIW'(N_PORTS)) begin
        cand = cand - CIW'(N_PORTS);
      end
      if (!hit && req[cand[IDW-1:0]]) begin
        hit     = 1'b1;
        hit_idx = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= IDW'(N_PORTS - 1);
      beat_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_src_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_src_q    <= m_src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_src_d    = m_src_q;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          gnt_d      = hit_idx;
          rr_ptr_d   = hit_idx;
          beat_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        // Backpressure alone never releases the grant; the beat of the exit cycle still moves.
        if ((xfer && beat_cnt_q == LAST_BEAT) || !gnt_en || (load_ok && !gnt_valid)) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = gnt_data;
      m_src_d   = gnt_q;
    end else if (load_ok) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    s_ready = '0;
    busy    = 1'b0;
    if (state_q == S_GRANT) begin
      busy           = 1'b1;
      s_ready[gnt_q] = gnt_rdy;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_src   = m_src_q;

endmodule
